// File: rtl/beep_arbiter.sv
// Buzzer arbiter: shares one buzzer between background music and four
// one-shot sound effects. Latches effect requests, grants one effect at a
// time by fixed priority (bit 3 highest), times each effect, inserts a
// silent gap between effects and enables music only when idle.
module beep_arbiter #(
  parameter int unsigned TICK_CYCLES = 100000,
  parameter int unsigned DUR0        = 120,
  parameter int unsigned DUR1        = 200,
  parameter int unsigned DUR2        = 300,
  parameter int unsigned DUR3        = 1000,
  parameter int unsigned GAP_TICKS   = 20,
  parameter logic [1:0]  BGM_MODE    = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] gamemode,
  input  logic       mute,
  input  logic [3:0] sfx_req,
  input  logic [3:0] sfx_beep,
  input  logic       bgm_beep,
  output logic [3:0] sfx_grant,
  output logic       bgm_en,
  output logic       busy,
  output logic       beep
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned DW = 16;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  // Last duration-counter value of each phase; zero durations act as one tick.
  localparam logic [DW-1:0] DUR_LAST0 = DW'((DUR0 == 0) ? 0 : DUR0 - 1);
  localparam logic [DW-1:0] DUR_LAST1 = DW'((DUR1 == 0) ? 0 : DUR1 - 1);
  localparam logic [DW-1:0] DUR_LAST2 = DW'((DUR2 == 0) ? 0 : DUR2 - 1);
  localparam logic [DW-1:0] DUR_LAST3 = DW'((DUR3 == 0) ? 0 : DUR3 - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);
  localparam logic          HAS_GAP   = (GAP_TICKS != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      pending, pending_nxt;
  logic [1:0]      cur, cur_nxt;
  logic [TW-1:0]   tick_cnt, tick_nxt;
  logic [DW-1:0]   dur_cnt, dur_nxt;
  logic [3:0]      grant_nxt;
  logic            bgm_nxt;
  logic            busy_nxt;
  logic            beep_nxt;

  logic [3:0]      req_all;
  logic            req_any;
  logic [1:0]      sel;
  logic [3:0]      clear;
  logic [DW-1:0]   dur_last;
  logic            tick_wrap;

  // Next-state, counters, request bookkeeping and registered-output values
  always_comb begin
    req_all   = pending | sfx_req;
    req_any   = (req_all != 4'b0000);
    sel       = 2'd0;
    if (req_all[3])      sel = 2'd3;
    else if (req_all[2]) sel = 2'd2;
    else if (req_all[1]) sel = 2'd1;
    else                 sel = 2'd0;

    case (cur)
      2'd0:    dur_last = DUR_LAST0;
      2'd1:    dur_last = DUR_LAST1;
      2'd2:    dur_last = DUR_LAST2;
      default: dur_last = DUR_LAST3;
    endcase

    tick_wrap = (tick_cnt == TICK_LAST);

    state_nxt = state;
    cur_nxt   = cur;
    tick_nxt  = tick_wrap ? '0 : tick_cnt + TW'(1);
    dur_nxt   = tick_wrap ? dur_cnt + DW'(1) : dur_cnt;
    clear     = 4'b0000;

    case (state)
      IDLE: begin
        tick_nxt = '0;
        dur_nxt  = '0;
        if (req_any) begin
          state_nxt = PLAY;
          cur_nxt   = sel;
          clear     = 4'b0001 << sel;
        end
      end
      PLAY: begin
        if (req_any && (sel > cur)) begin
          // Higher-priority effect takes over immediately; old one is dropped
          cur_nxt  = sel;
          clear    = 4'b0001 << sel;
          tick_nxt = '0;
          dur_nxt  = '0;
        end else if (tick_wrap && (dur_cnt == dur_last)) begin
          state_nxt = HAS_GAP ? GAP : IDLE;
          tick_nxt  = '0;
          dur_nxt   = '0;
        end
      end
      GAP: begin
        if (tick_wrap && (dur_cnt == GAP_LAST)) begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          dur_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        tick_nxt  = '0;
        dur_nxt   = '0;
      end
    endcase

    pending_nxt = req_all & ~clear;
    grant_nxt   = (state_nxt == PLAY) ? (4'b0001 << cur_nxt) : 4'b0000;
    busy_nxt    = (state_nxt != IDLE);
    bgm_nxt     = (state == IDLE) && (gamemode == BGM_MODE) && !req_any;

    if (mute)               beep_nxt = 1'b0;
    else if (state == PLAY) beep_nxt = sfx_beep[cur];
    else if (bgm_en)        beep_nxt = bgm_beep;
    else                    beep_nxt = 1'b0;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 4'b0000;
      cur       <= 2'd0;
      tick_cnt  <= '0;
      dur_cnt   <= '0;
      sfx_grant <= 4'b0000;
      bgm_en    <= 1'b0;
      busy      <= 1'b0;
      beep      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      cur       <= cur_nxt;
      tick_cnt  <= tick_nxt;
      dur_cnt   <= dur_nxt;
      sfx_grant <= grant_nxt;
      bgm_en    <= bgm_nxt;
      busy      <= busy_nxt;
      beep      <= beep_nxt;
    end
  end

endmodule

// File: tb/tb_beep_arbiter.sv
// Self-checking bench for beep_arbiter: directed scenarios plus random
// requests, compared cycle by cycle against a countdown-based model.
module tb_beep_arbiter;

  localparam int unsigned T   = 4;
  localparam int unsigned GAP = 1;

  logic       clk;
  logic       rst;
  logic [1:0] gamemode;
  logic       mute;
  logic [3:0] sfx_req;
  logic [3:0] sfx_beep;
  logic       bgm_beep;
  logic [3:0] sfx_grant;
  logic       bgm_en;
  logic       busy;
  logic       beep;

  int n_total;
  int n_bad;

  // Model: mode 0=idle 1=play 2=gap, remaining cycles in the current phase
  int         m_mode;
  int         m_cur;
  int         m_left;
  logic [3:0] m_pend;
  logic [3:0] m_grant;
  logic       m_bgm;
  logic       m_busy;
  logic       m_beep;

  beep_arbiter #(
    .TICK_CYCLES(T),
    .DUR0(2), .DUR1(3), .DUR2(4), .DUR3(5),
    .GAP_TICKS(GAP),
    .BGM_MODE(2'b00)
  ) dut (
    .clk(clk), .rst(rst), .gamemode(gamemode), .mute(mute),
    .sfx_req(sfx_req), .sfx_beep(sfx_beep), .bgm_beep(bgm_beep),
    .sfx_grant(sfx_grant), .bgm_en(bgm_en), .busy(busy), .beep(beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dur_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int hi_bit(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_left = 0; m_pend = 4'b0000;
    m_grant = 4'b0000; m_bgm = 1'b0; m_busy = 1'b0; m_beep = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    logic [3:0] req;
    int         h;
    logic       n_beep;
    logic       n_bgm;
    req = m_pend | sfx_req;
    h   = hi_bit(req);
    if (mute)             n_beep = 1'b0;
    else if (m_mode == 1) n_beep = sfx_beep[m_cur];
    else if (m_bgm)       n_beep = bgm_beep;
    else                  n_beep = 1'b0;
    n_bgm = (m_mode == 0) && (gamemode == 2'b00) && (req == 4'b0000);
    case (m_mode)
      0: begin
        if (h >= 0) begin
          m_mode = 1; m_cur = h; m_left = dur_of(h) * T;
          m_pend = req & ~(4'(1) << h);
        end else m_pend = req;
      end
      1: begin
        if (h > m_cur) begin
          m_cur = h; m_left = dur_of(h) * T;
          m_pend = req & ~(4'(1) << h);
        end else begin
          m_pend = req;
          m_left--;
          if (m_left == 0) begin
            if (GAP > 0) begin m_mode = 2; m_left = GAP * T; end
            else m_mode = 0;
          end
        end
      end
      default: begin
        m_pend = req;
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
    m_grant = (m_mode == 1) ? (4'(1) << m_cur) : 4'b0000;
    m_busy  = (m_mode != 0);
    m_bgm   = n_bgm;
    m_beep  = n_beep;
  endtask

  task automatic compare_all();
    check("sfx_grant", 32'(sfx_grant), 32'(m_grant));
    check("bgm_en", 32'(bgm_en), 32'(m_bgm));
    check("busy", 32'(busy), 32'(m_busy));
    check("beep", 32'(beep), 32'(m_beep));
    check("pending", 32'(dut.pending), 32'(m_pend));
  endtask

  // One clock: drive request and random tone inputs, step model, compare
  task automatic run_cycle(input logic [3:0] req);
    sfx_req  = req;
    sfx_beep = 4'($urandom);
    bgm_beep = 1'($urandom);
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(4'b0000);
  endtask

  initial begin
    logic [3:0] r;
    n_total = 0; n_bad = 0;
    rst = 1'b1; gamemode = 2'b00; mute = 1'b0;
    sfx_req = 4'b0000; sfx_beep = 4'b0000; bgm_beep = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(sfx_grant), 32'h0);
    check("rst_bgm", 32'(bgm_en), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_beep", 32'(beep), 32'h0);
    rst = 1'b0;

    // Music when idle, then leave music mode and return
    run_idle(4);
    gamemode = 2'b01;
    run_idle(3);
    gamemode = 2'b00;
    run_idle(3);

    // Single lowest-priority effect with gap
    run_cycle(4'b0001);
    run_idle(16);

    // Two same-cycle requests: effect 2 first, effect 0 afterwards
    run_cycle(4'b0101);
    run_idle(36);

    // Effect 1 preempted by effect 3 at its fifth play cycle
    run_cycle(4'b0010);
    run_idle(4);
    run_cycle(4'b1000);
    run_idle(30);

    // Mute during effect 3
    run_cycle(4'b1000);
    mute = 1'b1;
    run_idle(10);
    mute = 1'b0;
    run_idle(20);

    // Replay request for the effect currently playing
    run_cycle(4'b0100);
    run_idle(3);
    run_cycle(4'b0100);
    run_idle(45);

    // Asynchronous reset in the middle of effect 2
    run_cycle(4'b0100);
    run_cycle(4'b0001);
    run_idle(1);
    rst = 1'b1;
    #1;
    check("async_grant", 32'(sfx_grant), 32'h0);
    check("async_beep", 32'(beep), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_pending", 32'(dut.pending), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);
    run_idle(3);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) mute = ~mute;
      if ($urandom_range(0, 99) == 0) gamemode = 2'($urandom);
      r = 4'b0000;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 23) == 0) r[b] = 1'b1;
      run_cycle(r);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
